regfile_wr_sched: RTL and testbench
===================================

# regfile_wr_sched

Write-port scheduler for the 32 x 32-bit register file. Shares the file's single write port (`regwr`/`rw`/`busW`) between two writeback requesters using a valid/ready handshake and round-robin arbitration. After reset, and on a software clear request, it walks the whole file and writes zero to every register before accepting traffic. Sits between the execute/memory writeback stages and the register file's write inputs.

## Interface

Reset is asynchronous and active-high. The block has one clock, `wrclk`, and one reset, `rst`.

Parameters:
- `DW`, default 32: register data width.
- `AW`, default 5: register address width. The file has 2^AW entries.

Ports:
- `wrclk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `clr`  in  1  request to re-zero the whole file; sampled each cycle.
- `req0_valid`  in  1  requester 0 has a write pending.
- `req0_rw`  in  AW  requester 0 target register.
- `req0_data`  in  DW  requester 0 write data.
- `req0_ready`  out  1  requester 0 write accepted this cycle (combinational).
- `req1_valid`, `req1_rw`, `req1_data`, `req1_ready`: same as requester 0, for requester 1.
- `regwr`  out  1  registered write enable to the register file.
- `rw`  out  AW  registered write address.
- `busW`  out  DW  registered write data.
- `init_done`  out  1  high once a clear sweep has completed; low during a sweep.

## Operation

- FSM states:
  - CLEAR: zero sweep.
  - RUN: arbitration.
- Reset values:
  - state = CLEAR, sweep counter `cnt` = 1, round-robin pointer `ptr` = 0 (requester 0 preferred).
  - `regwr` = 0, `rw` = 0, `busW` = 0, `init_done` = 0.
  - `req0_ready` and `req1_ready` are 0 while in CLEAR.
- CLEAR state:
  - Each cycle the output register loads `regwr`=1, `rw`=`cnt`, `busW`=0, then `cnt` increments.
  - Address 0 is never written; it is hardwired zero in the file.
  - When `cnt` = 2^AW−1 is issued, the next state is RUN and `init_done` is set on that same edge.
  - Both readies are held at 0 throughout CLEAR.
- RUN state, arbitration:
  - Only one valid: that requester gets ready=1.
  - Both valid: the requester selected by `ptr` wins; the other sees ready=0 and must hold its request stable.
  - No valid: both readies are 0.
- RUN state, accepted transfer (valid && ready):
  - The next edge loads `regwr`=1, `rw`=req_rw, `busW`=req_data.
  - `ptr` moves to the other requester, but only when both requesters were valid in that cycle.
- RUN state, no transfer: the next edge loads `regwr`=0; `rw` and `busW` hold their values.
- Writes to `rw`=0: the handshake completes normally (ready=1), but the next edge loads `regwr`=0. The write is dropped and `ptr` still updates.
- `clr` in RUN:
  - Forces both readies to 0 that cycle; `clr` takes precedence over requests.
  - Next edge: state = CLEAR, `cnt` = 1, `init_done` = 0, `regwr` = 0.
  - The sweep write to address 1 appears one edge later.
- `clr` in CLEAR: restarts the sweep. Next edge: `cnt` = 1, `regwr` = 0.
- `rst` asserted at any time, including mid-sweep or mid-transfer: all state returns immediately to the reset values. An in-flight accepted write is lost.

## Timing

- Accept-to-write latency: 1 cycle. The handshake occurs in cycle N; `regwr`/`rw`/`busW` are valid during cycle N+1 and the register file captures them at the end of N+1.
- Throughput: one write per cycle sustained. No bubble between back-to-back grants.
- Sweep length: 2^AW−1 cycles (31 by default).
  - The first sweep write is on the first edge after `rst` deasserts.
  - `init_done` rises with the `rw`=31 write.
  - The first requester can be accepted in the cycle after that write.
- Readies depend combinationally on valids, state, `ptr` and `clr`. There is no combinational path from `req*_data` or `req*_rw` to any output.

## Test plan

- **Reset sweep:** deassert `rst`, keep both valids high. Required response:
  - `regwr`=1 with `rw`=1..31 and `busW`=0 on 31 consecutive edges.
  - Readies stay 0 throughout; `init_done`=1 from the 31st edge.
- **Single requester:** in RUN, `req0_valid`=1, `req0_rw`=5, `req0_data`=0xDEADBEEF for one cycle. Required response:
  - `req0_ready`=1 that cycle.
  - Next cycle `regwr`=1, `rw`=5, `busW`=0xDEADBEEF; the cycle after, `regwr`=0.
- **Contention:** both requesters valid continuously, req0→r3=0x11, req1→r4=0x22, each deasserting after acceptance. Required response:
  - Grants alternate req0 then req1.
  - Writes appear on consecutive cycles: `rw`=3 `busW`=0x11, then `rw`=4 `busW`=0x22.
- **Zero-register write:** req1 writes `rw`=0, data 0x1234. Required response: `req1_ready`=1, following cycle `regwr`=0.
- **Clear mid-traffic:** pulse `clr` while req0 is valid. Required response:
  - `req0_ready`=0 that cycle.
  - `init_done` falls on the next edge.
  - The sweep restarts at `rw`=1; req0 is accepted only after `rw`=31 is issued.
- **Async reset mid-sweep:** assert `rst` between edges when `rw`=12. Required response:
  - `regwr`, `rw`, `busW` and `init_done` go to 0 immediately, without waiting for a clock edge.
  - After release, the sweep restarts at `rw`=1.

Source files
------------

// File: rtl/regfile_wr_sched_if.sv
// Writeback port bundle for regfile_wr_sched: two requester handshakes, clear request,
// and the registered write port that drives the register file.
interface regfile_wr_sched_if #(
  parameter int DW = 32,
  parameter int AW = 5
) ();
  // Handshake: a requester raises valid with rw/data and holds them stable until it
  // sees ready=1 in the same cycle; that cycle is the transfer. ready never waits on data.
  logic          clr;
  logic          req0_valid;
  logic [AW-1:0] req0_rw;
  logic [DW-1:0] req0_data;
  logic          req0_ready;
  logic          req1_valid;
  logic [AW-1:0] req1_rw;
  logic [DW-1:0] req1_data;
  logic          req1_ready;
  logic          regwr;
  logic [AW-1:0] rw;
  logic [DW-1:0] busW;
  logic          init_done;

  modport master (
    output clr, req0_valid, req0_rw, req0_data, req1_valid, req1_rw, req1_data,
    input  req0_ready, req1_ready, regwr, rw, busW, init_done
  );

  modport slave (
    input  clr, req0_valid, req0_rw, req0_data, req1_valid, req1_rw, req1_data,
    output req0_ready, req1_ready, regwr, rw, busW, init_done
  );
endinterface

// File: rtl/regfile_wr_sched.sv
// Register-file write-port scheduler: zero sweep after reset/clear, then round-robin
// arbitration of two writeback requesters onto one registered write port.
module regfile_wr_sched #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic               wrclk,
  input  logic               rst,
  regfile_wr_sched_if.slave  bus,
  output logic               dbg_state
);

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  localparam logic [AW-1:0] ONE  = AW'(1);
  localparam logic [AW-1:0] LAST = '1;

  state_t        state, state_n;
  logic [AW-1:0] cnt, cnt_n;
  logic          ptr, ptr_n;
  logic          regwr_q, regwr_n;
  logic [AW-1:0] rw_q, rw_n;
  logic [DW-1:0] busw_q, busw_n;
  logic          done_q, done_n;
  logic          gnt0, gnt1, both;

  always_ff @(posedge wrclk or posedge rst) begin
    if (rst) begin
      state   <= CLEAR;
      cnt     <= ONE;
      ptr     <= 1'b0;
      regwr_q <= 1'b0;
      rw_q    <= '0;
      busw_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      ptr     <= ptr_n;
      regwr_q <= regwr_n;
      rw_q    <= rw_n;
      busw_q  <= busw_n;
      done_q  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ptr_n   = ptr;
    regwr_n = 1'b0;
    rw_n    = rw_q;
    busw_n  = busw_q;
    done_n  = done_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    both    = bus.req0_valid & bus.req1_valid;
    case (state)
      CLEAR: begin
        if (bus.clr) begin
          cnt_n = ONE;
        end else begin
          // Sweep starts at 1: register 0 is hardwired zero in the file.
          regwr_n = 1'b1;
          rw_n    = cnt;
          busw_n  = '0;
          cnt_n   = cnt + ONE;
          if (cnt == LAST) begin
            state_n = RUN;
            done_n  = 1'b1;
          end
        end
      end
      RUN: begin
        if (bus.clr) begin
          state_n = CLEAR;
          cnt_n   = ONE;
          done_n  = 1'b0;
        end else begin
          gnt0 = bus.req0_valid & (~bus.req1_valid | ~ptr);
          gnt1 = bus.req1_valid & (~bus.req0_valid |  ptr);
          // A write to register 0 is acknowledged but never reaches the file.
          if (gnt0 && bus.req0_rw != '0) begin
            regwr_n = 1'b1;
            rw_n    = bus.req0_rw;
            busw_n  = bus.req0_data;
          end else if (gnt1 && bus.req1_rw != '0) begin
            regwr_n = 1'b1;
            rw_n    = bus.req1_rw;
            busw_n  = bus.req1_data;
          end
          if (both) ptr_n = ~ptr;
        end
      end
      default: state_n = CLEAR;
    endcase
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.regwr      = regwr_q;
  assign bus.rw         = rw_q;
  assign bus.busW       = busw_q;
  assign bus.init_done  = done_q;
  assign dbg_state      = (state == RUN);

endmodule

// File: tb/tb_regfile_wr_sched.sv
// Self-checking bench for regfile_wr_sched: scoreboard of expected register-file writes
// plus per-scenario inline checks of readies, init_done and the write port.
module tb_regfile_wr_sched;
  localparam int DW = 32;
  localparam int AW = 5;

  logic wrclk;
  logic rst;
  logic dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] exp_w;
  logic             mptr;

  regfile_wr_sched_if #(.DW(DW), .AW(AW)) bus ();

  regfile_wr_sched #(.DW(DW), .AW(AW)) dut (
    .wrclk     (wrclk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    wrclk = 1'b0;
    forever #5 wrclk = ~wrclk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge wrclk) begin
    if (bus.regwr === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL wr_unexpected: got rw=%0d busW=%h, required no write", bus.rw, bus.busW);
      end else begin
        exp_w = exp_q.pop_front();
        if ({bus.rw, bus.busW} !== exp_w) begin
          n_fail++;
          $display("FAIL wr_data: got rw=%0d busW=%h, required rw=%0d busW=%h",
                   bus.rw, bus.busW, exp_w[AW+DW-1:DW], exp_w[DW-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    bus.clr        = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req0_rw    = '0;
    bus.req0_data  = '0;
    bus.req1_valid = 1'b0;
    bus.req1_rw    = '0;
    bus.req1_data  = '0;
  endtask

  task automatic set_req0(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req0_valid = v;
    bus.req0_rw    = a;
    bus.req0_data  = d;
  endtask

  task automatic set_req1(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req1_valid = v;
    bus.req1_rw    = a;
    bus.req1_data  = d;
  endtask

  task automatic push_sweep(input int first, input int last);
    for (int k = first; k <= last; k++) exp_q.push_back({AW'(k), {DW{1'b0}}});
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    n_checks++;
    if ({bus.regwr, bus.rw, bus.busW, bus.init_done} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got regwr=%b rw=%0d busW=%h init_done=%b, required all 0",
               bus.regwr, bus.rw, bus.busW, bus.init_done);
    end
    n_checks++;
    if (dbg_state !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got %b, required 0 (CLEAR)", dbg_state);
    end
  endtask

  task automatic test_reset_sweep();
    set_req0(1'b1, 5'd7, 32'hAAAA_0007);
    set_req1(1'b1, 5'd8, 32'hBBBB_0008);
    #1;
    n_checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL sweep_ready_in_reset: got %b%b, required 00", bus.req0_ready, bus.req1_ready);
    end
    push_sweep(1, 31);
    rst = 1'b0;
    for (int i = 1; i <= 31; i++) begin
      @(negedge wrclk);
      n_checks++;
      if (bus.init_done !== (i == 31)) begin
        n_fail++;
        $display("FAIL sweep_init_done: edge %0d got %b, required %b", i, bus.init_done, (i == 31));
      end
      n_checks++;
      if (i < 31 && {bus.req0_ready, bus.req1_ready} !== 2'b00) begin
        n_fail++;
        $display("FAIL sweep_ready: edge %0d got %b%b, required 00", i, bus.req0_ready, bus.req1_ready);
      end else if (i == 31 && {bus.req0_ready, bus.req1_ready} !== 2'b10) begin
        n_fail++;
        $display("FAIL first_grant: got %b%b, required 10", bus.req0_ready, bus.req1_ready);
      end
    end
    drive_idle();
    mptr = 1'b0;
  endtask

  task automatic test_single();
    set_req0(1'b1, 5'd5, 32'hDEAD_BEEF);
    #1;
    n_checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL single_ready: got %b%b, required 10", bus.req0_ready, bus.req1_ready);
    end
    exp_q.push_back({5'd5, 32'hDEAD_BEEF});
    @(negedge wrclk);
    drive_idle();
    n_checks++;
    if ({bus.regwr, bus.rw, bus.busW} !== {1'b1, 5'd5, 32'hDEAD_BEEF}) begin
      n_fail++;
      $display("FAIL single_write: got regwr=%b rw=%0d busW=%h, required 1/5/deadbeef",
               bus.regwr, bus.rw, bus.busW);
    end
    @(negedge wrclk);
    n_checks++;
    if (bus.regwr !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle: got regwr=%b, required 0", bus.regwr);
    end
  endtask

  task automatic test_contention();
    // req0 preferred first (ptr=0), each side drops after its grant.
    set_req0(1'b1, 5'd3, 32'h11);
    set_req1(1'b1, 5'd4, 32'h22);
    #1;
    n_checks++;
    if ({bus.req0_ready, bus.req1_ready} !== {~mptr, mptr}) begin
      n_fail++;
      $display("FAIL contend_grant0: got %b%b, required %b%b", bus.req0_ready, bus.req1_ready, ~mptr, mptr);
    end
    exp_q.push_back({5'd3, 32'h11});
    mptr = ~mptr;
    @(negedge wrclk);
    set_req0(1'b0, '0, '0);
    #1;
    n_checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL contend_grant1: got %b%b, required 01", bus.req0_ready, bus.req1_ready);
    end
    exp_q.push_back({5'd4, 32'h22});
    @(negedge wrclk);
    set_req1(1'b0, '0, '0);
    n_checks++;
    if ({bus.regwr, bus.rw, bus.busW} !== {1'b1, 5'd4, 32'h22}) begin
      n_fail++;
      $display("FAIL contend_back_to_back: got regwr=%b rw=%0d busW=%h, required 1/4/22",
               bus.regwr, bus.rw, bus.busW);
    end
    // Pointer now favours req1; sustained contention alternates with no bubble.
    set_req0(1'b1, 5'd6, 32'h66);
    set_req1(1'b1, 5'd7, 32'h77);
    #1;
    n_checks++;
    if ({bus.req0_ready, bus.req1_ready} !== {~mptr, mptr}) begin
      n_fail++;
      $display("FAIL rr_grant_a: got %b%b, required %b%b", bus.req0_ready, bus.req1_ready, ~mptr, mptr);
    end
    exp_q.push_back({5'd7, 32'h77});
    mptr = ~mptr;
    @(negedge wrclk);
    set_req1(1'b1, 5'd9, 32'h99);
    #1;
    n_checks++;
    if ({bus.req0_ready, bus.req1_ready} !== {~mptr, mptr}) begin
      n_fail++;
      $display("FAIL rr_grant_b: got %b%b, required %b%b", bus.req0_ready, bus.req1_ready, ~mptr, mptr);
    end
    exp_q.push_back({5'd6, 32'h66});
    mptr = ~mptr;
    @(negedge wrclk);
    set_req0(1'b0, '0, '0);
    #1;
    n_checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL rr_grant_c: got %b%b, required 01", bus.req0_ready, bus.req1_ready);
    end
    exp_q.push_back({5'd9, 32'h99});
    @(negedge wrclk);
    drive_idle();
    @(negedge wrclk);
  endtask

  task automatic test_zero_write();
    set_req1(1'b1, 5'd0, 32'h1234);
    #1;
    n_checks++;
    if (bus.req1_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_ready: got %b, required 1", bus.req1_ready);
    end
    @(negedge wrclk);
    drive_idle();
    n_checks++;
    if (bus.regwr !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_dropped: got regwr=%b, required 0", bus.regwr);
    end
  endtask

  task automatic test_clear_mid_traffic();
    logic [DW-1:0] d;
    d = DW'($urandom_range(1, 32'h7FFF_FFFF));
    set_req0(1'b1, 5'd10, d);
    bus.clr = 1'b1;
    #1;
    n_checks++;
    if (bus.req0_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_ready: got %b, required 0", bus.req0_ready);
    end
    @(negedge wrclk);
    bus.clr = 1'b0;
    #1;
    n_checks++;
    if ({bus.init_done, bus.regwr, dbg_state, bus.req0_ready} !== 4'b0000) begin
      n_fail++;
      $display("FAIL clr_enter: got init_done=%b regwr=%b state=%b ready=%b, required 0000",
               bus.init_done, bus.regwr, dbg_state, bus.req0_ready);
    end
    push_sweep(1, 31);
    for (int i = 1; i <= 31; i++) begin
      @(negedge wrclk);
      n_checks++;
      if (bus.req0_ready !== (i == 31)) begin
        n_fail++;
        $display("FAIL clr_sweep_ready: edge %0d got %b, required %b", i, bus.req0_ready, (i == 31));
      end
    end
    exp_q.push_back({5'd10, d});
    @(negedge wrclk);
    drive_idle();
    @(negedge wrclk);
  endtask

  task automatic test_async_reset();
    bus.clr = 1'b1;
    @(negedge wrclk);
    bus.clr = 1'b0;
    push_sweep(1, 12);
    repeat (12) @(negedge wrclk);
    n_checks++;
    if (bus.rw !== 5'd12) begin
      n_fail++;
      $display("FAIL async_pre: got rw=%0d, required 12", bus.rw);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.regwr, bus.rw, bus.busW, bus.init_done} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got regwr=%b rw=%0d busW=%h init_done=%b, required all 0",
               bus.regwr, bus.rw, bus.busW, bus.init_done);
    end
    @(negedge wrclk);
    push_sweep(1, 31);
    rst = 1'b0;
    repeat (31) @(negedge wrclk);
    n_checks++;
    if ({bus.init_done, dbg_state} !== 2'b11) begin
      n_fail++;
      $display("FAIL async_resweep: got init_done=%b state=%b, required 11", bus.init_done, dbg_state);
    end
    // Reset must return the pointer to req0.
    mptr = 1'b0;
    set_req0(1'b1, 5'd20, 32'h2020);
    set_req1(1'b1, 5'd21, 32'h2121);
    #1;
    n_checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL async_ptr: got %b%b, required 10", bus.req0_ready, bus.req1_ready);
    end
    exp_q.push_back({5'd20, 32'h2020});
    @(negedge wrclk);
    drive_idle();
    repeat (2) @(negedge wrclk);
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    rst = 1'b1;
    drive_idle();
    mptr = 1'b0;
    @(negedge wrclk);
    test_reset();
    test_reset_sweep();
    test_single();
    test_contention();
    test_zero_write();
    test_clear_mid_traffic();
    test_async_reset();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d writes outstanding, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
